gshare_bp: RTL and testbench
============================

# gshare_bp

Parametrised direction predictor for the fetch stage: a table of 2^IDX_W saturating counters of CTR_W bits, indexed by PC alone (bimodal mode) or by PC XOR global history (gshare mode). Predictions are registered with one-cycle latency. Updates arrive from execute through a separate port that carries back the table index used at predict time. After reset or flush, a sequential sweep re-initialises the table before the block accepts traffic.

## Interface
- IDX_W, 12, index width; the table holds 2^IDX_W entries.
- CTR_W, 2, counter width; must be ≥2. Predict taken when the counter MSB is 1.
- HIST_W, 8, global history length; must be ≤ IDX_W.
- clk  in  1  clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = bimodal, 1 = gshare; sampled with each request.
- flush  in  1  single-cycle pulse; restarts the init sweep and clears history.
- ready  out  1  1 when the sweep is done and the table is usable.
- pred_req  in  1  prediction request.
- pred_pc  in  32  fetch PC.
- pred_valid  out  1  prediction result valid, one cycle after pred_req.
- pred_taken  out  1  predicted direction.
- pred_idx  out  IDX_W  table index used; travels down the pipe to the update port.
- upd_en  in  1  a resolved branch is present.
- upd_idx  in  IDX_W  index returned from pred_idx.
- upd_taken  in  1  actual branch outcome.
- ghr  out  HIST_W  current global history, for debug and checkpointing.

## Operation
- Index calculation:
  - pc_idx = pred_pc[IDX_W+1:2].
  - Bimodal mode: idx = pc_idx.
  - Gshare mode: idx = pc_idx XOR zero-extend(ghr), so the history XORs into the low bits.
- Counters:
  - INIT = 2^(CTR_W-1), i.e. weakly taken; this is 2'b10 when CTR_W=2.
  - Taken increments, saturating at all-ones.
  - Not-taken decrements, saturating at 0.
  - Counter arithmetic is exactly CTR_W bits wide, with no wrap.
- GHR: on each accepted update, ghr <= {ghr[HIST_W-2:0], upd_taken}; the newest outcome goes in the LSB. The GHR is updated at resolution, never speculatively.
- FSM states:
  - INIT: a sweep counter writes INIT to one entry per cycle, from 0 up to 2^IDX_W-1. ready=0. Requests produce pred_valid=0. Updates are dropped and the GHR is untouched.
  - RUN: the last sweep write moves the FSM to RUN; ready=1 from the next cycle.
  - RUN → INIT on flush. The sweep counter is zeroed and the GHR is cleared in the same cycle.
  - flush during INIT restarts the sweep at 0.
- Same-cycle update and request: the update is applied first. If upd_idx equals the computed request index, the prediction reflects the post-update counter (write-first forwarding). The request index uses the ghr value from before this cycle's shift.
- Only one table write happens per cycle. There is no upd_ready; the update port is never stalled in RUN.

## Timing
- Reset values:
  - FSM = INIT and the sweep counter = 0.
  - ready=0, pred_valid=0, pred_taken=0, pred_idx=0, ghr=0.
  - Table contents are not reset by rst; the sweep initialises them.
- The first ready=1 occurs 2^IDX_W cycles after rst deasserts.
- Prediction latency is 1 cycle: a pred_req in cycle t drives pred_valid, pred_taken and pred_idx in cycle t+1. With no request, pred_valid=0 and pred_taken/pred_idx hold their previous values.
- Updates become visible to a request in the same cycle through forwarding, and to later requests through the table.
- rst asserted mid-sweep or mid-run returns to the reset state asynchronously, and the sweep restarts after release.

## Structure
- Shared package bp_pkg holds:
  - the mode enum (BP_BIMODAL, BP_GSHARE);
  - the FSM state enum (BP_INIT, BP_RUN);
  - a function that computes the INIT value for a given CTR_W.
- One sub-module, bp_sat_counter: a combinational saturating next-value function (CTR_W, taken) → next counter.
- The table is a plain reg array so it can map to RAM later. Read and write are synchronous, plus the forwarding mux.

## Test plan
All scenarios use IDX_W=12, CTR_W=2 and HIST_W=8 unless stated otherwise.
- Reset/sweep:
  - Stimulus: release rst and issue pred_req every cycle.
  - Required: ready=0 and pred_valid=0 for 4096 cycles. The first prediction after ready=1 is taken (every counter = 2'b10) for pc=0x0000_0100.
- Saturation, bimodal mode, pc=0x40 (idx 0x010):
  - Apply 3 updates taken → counter 11, predict taken.
  - Then 3 updates not-taken → counter 00, predict not-taken.
  - Then 1 update taken → counter 01, still not-taken.
- Gshare index:
  - Apply 8 updates with outcomes 1,0,1,1,0,0,1,0 → ghr=0xB2.
  - Request pc=0x400 (pc_idx 0x100) in gshare mode → pred_idx=0x1B2.
  - Same request in bimodal mode → pred_idx=0x100.
- Collision forwarding:
  - Set the counter at idx 0x010 to 01.
  - In a single cycle, issue an update taken on 0x010 together with pred_req pc=0x40 (bimodal).
  - Required: pred_taken=1 in the following cycle (counter now 10).
- Flush mid-run:
  - Pulse flush while ghr=0xB2 and counter[0x010]=00.
  - Required: next cycle ghr=0 and ready=0; 4096 cycles later counter[0x010] reads taken.
  - An update issued during the sweep leaves ghr at 0.
- Parameter sweep: rerun the saturation test with IDX_W=4 and CTR_W=3.
  - Required: the sweep lasts 16 cycles, INIT=100, and the counter saturates at 111 and at 000.

Source files
------------

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the gshare/bimodal branch direction predictor.
//   bp_mode_e    : index mode selected per request (bimodal or gshare)
//   bp_state_e   : predictor FSM state (table init sweep or normal run)
//   ctr_init_val : weakly-taken counter value 2^(ctr_w-1) for a counter width
// -----------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // Weakly taken: only the MSB set, so one not-taken outcome flips the
  // prediction.
  function automatic int ctr_init_val(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// Combinational next-value function for a CTR_W-bit saturating counter.
//   ctr   : current counter value
//   taken : branch outcome (1 = increment, 0 = decrement)
//   nxt   : next counter value, clamped at all-ones and at zero
// -----------------------------------------------------------------------------
module bp_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] nxt
);

  always_comb begin
    // NOTE: default first so every path assigns nxt; otherwise a latch is inferred.
    nxt = ctr;
    if (taken) begin
      if (ctr != '1) nxt = ctr + CTR_W'(1);
    end else begin
      if (ctr != '0) nxt = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/gshare_bp.sv
// -----------------------------------------------------------------------------
// gshare_bp
// Direction predictor: 2^IDX_W saturating counters indexed by PC (bimodal)
// or PC XOR global history (gshare). One-cycle registered prediction, update
// port from execute carrying back the predict-time index, and a sequential
// sweep that initialises the table after reset or flush.
//   clk, rst (async, active low)
//   mode       : 0 = bimodal, 1 = gshare, sampled with each request
//   flush      : restart the init sweep and clear the history
//   ready      : table initialised and usable
//   pred_req/pred_pc -> pred_valid/pred_taken/pred_idx (one cycle later)
//   upd_en/upd_idx/upd_taken : resolved branch from execute
//   ghr        : global history, newest outcome in the LSB
// -----------------------------------------------------------------------------
module gshare_bp
  import bp_pkg::*;
#(
  parameter int IDX_W  = 12,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              flush,
  output logic              ready,
  input  logic              pred_req,
  input  logic [31:0]       pred_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  output logic [HIST_W-1:0] ghr
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(ctr_init_val(CTR_W));

  if (CTR_W < 2) begin : g_bad_ctr_w
    $error("gshare_bp: CTR_W must be at least 2");
  end
  if (HIST_W < 2 || HIST_W > IDX_W) begin : g_bad_hist_w
    $error("gshare_bp: HIST_W must be in 2..IDX_W");
  end

  logic [CTR_W-1:0] ctr_tab [DEPTH];

  bp_state_e        state;
  logic [IDX_W-1:0] sweep_cnt;

  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] req_idx;
  logic             req_ok;
  logic             upd_fire;
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_nxt;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;

  // PC bits outside the index field carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  // History XORs into the low index bits; uses the ghr before this cycle's shift.
  assign pc_idx  = pred_pc[IDX_W+1:2];
  assign req_idx = (bp_mode_e'(mode) == BP_GSHARE) ? (pc_idx ^ IDX_W'(ghr)) : pc_idx;

  assign req_ok   = (state == BP_RUN) && pred_req && !flush;
  assign upd_fire = (state == BP_RUN) && upd_en && !flush;

  // Read-modify-write of the updated entry.
  assign upd_cur = ctr_tab[upd_idx];

  bp_sat_counter #(.CTR_W(CTR_W)) u_sat (
    .ctr   (upd_cur),
    .taken (upd_taken),
    .nxt   (upd_nxt)
  );

  // Single write port: the sweep owns it in INIT, the update port in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sweep_cnt;
    wr_data = INIT_VAL;
    if (state == BP_INIT) begin
      wr_en = 1'b1;
    end else if (upd_fire) begin
      wr_en   = 1'b1;
      wr_idx  = upd_idx;
      wr_data = upd_nxt;
    end
  end

  // NOTE: the table has no reset so it can map to RAM; the init sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (wr_en) ctr_tab[wr_idx] <= wr_data;
  end

  // Control FSM, sweep counter and global history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      state     <= BP_INIT;
      sweep_cnt <= '0;
      ready     <= 1'b0;
      ghr       <= '0;
    end else if (flush) begin
      state     <= BP_INIT;
      sweep_cnt <= '0;
      ready     <= 1'b0;
      ghr       <= '0;
    end else if (state == BP_INIT) begin
      sweep_cnt <= sweep_cnt + IDX_W'(1);
      if (sweep_cnt == '1) begin
        state <= BP_RUN;
        ready <= 1'b1;
      end
    end else if (upd_fire) begin
      ghr <= {ghr[HIST_W-2:0], upd_taken};
    end
  end

  // Registered prediction with write-first forwarding of a colliding update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= req_ok;
      if (req_ok) begin
        pred_idx   <= req_idx;
        pred_taken <= (upd_fire && (upd_idx == req_idx)) ? upd_nxt[CTR_W-1]
                                                         : ctr_tab[req_idx][CTR_W-1];
      end
    end
  end

endmodule

// File: tb/tb_gshare_bp.sv
// -----------------------------------------------------------------------------
// tb_gshare_bp
// Self-checking bench for gshare_bp: a default instance (IDX_W=12, CTR_W=2,
// HIST_W=8) and a small instance (IDX_W=4, CTR_W=3, HIST_W=4). Expected values
// are hand-computed and held in per-cycle vector tables plus short sequences.
// -----------------------------------------------------------------------------
module tb_gshare_bp;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Default-parameter instance.
  logic        rst, mode, flush, ready, pred_req, pred_valid, pred_taken;
  logic        upd_en, upd_taken;
  logic [31:0] pred_pc;
  logic [11:0] pred_idx, upd_idx;
  logic [7:0]  ghr;

  gshare_bp #(.IDX_W(12), .CTR_W(2), .HIST_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .flush      (flush),
    .ready      (ready),
    .pred_req   (pred_req),
    .pred_pc    (pred_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_idx   (pred_idx),
    .upd_en     (upd_en),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .ghr        (ghr)
  );

  // Small instance for the parameter sweep.
  logic        s_rst, s_mode, s_flush, s_ready, s_pred_req, s_pred_valid, s_pred_taken;
  logic        s_upd_en, s_upd_taken;
  logic [31:0] s_pred_pc;
  logic [3:0]  s_pred_idx, s_upd_idx, s_ghr;

  gshare_bp #(.IDX_W(4), .CTR_W(3), .HIST_W(4)) u_small (
    .clk        (clk),
    .rst        (s_rst),
    .mode       (s_mode),
    .flush      (s_flush),
    .ready      (s_ready),
    .pred_req   (s_pred_req),
    .pred_pc    (s_pred_pc),
    .pred_valid (s_pred_valid),
    .pred_taken (s_pred_taken),
    .pred_idx   (s_pred_idx),
    .upd_en     (s_upd_en),
    .upd_idx    (s_upd_idx),
    .upd_taken  (s_upd_taken),
    .ghr        (s_ghr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_small_ready(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (s_ready) begin
        n = i;
        break;
      end
    end
  endtask

  // One record per cycle: inputs applied, then outputs after the edge.
  typedef struct {
    logic        upd_en;
    logic [11:0] upd_idx;
    logic        upd_taken;
    logic        req;
    logic [31:0] pc;
    logic        mode;
    logic        exp_valid;
    logic        exp_taken;
    logic [11:0] exp_idx;
    logic [7:0]  exp_ghr;
  } vec_t;

  function automatic vec_t mk(int ue, int ui, int ut, int rq, int pc, int md,
                              int ev, int et, int ei, int eg);
    vec_t v;
    v.upd_en    = 1'(ue);
    v.upd_idx   = 12'(ui);
    v.upd_taken = 1'(ut);
    v.req       = 1'(rq);
    v.pc        = 32'(pc);
    v.mode      = 1'(md);
    v.exp_valid = 1'(ev);
    v.exp_taken = 1'(et);
    v.exp_idx   = 12'(ei);
    v.exp_ghr   = 8'(eg);
    return v;
  endfunction

  // Small instance: upd 0 = none, 1 = taken, 2 = not taken; request every cycle.
  typedef struct {
    int upd;
    int exp_taken;
  } svec_t;

  vec_t  vecs[$];
  svec_t svecs[19];

  initial begin
    int n;
    int bad;
    int gh_out[8];
    int gh_exp[8];

    rst = 1'b0; mode = 1'b0; flush = 1'b0; pred_req = 1'b0; pred_pc = '0;
    upd_en = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    s_rst = 1'b0; s_mode = 1'b0; s_flush = 1'b0; s_pred_req = 1'b0; s_pred_pc = '0;
    s_upd_en = 1'b0; s_upd_idx = '0; s_upd_taken = 1'b0;

    // Saturation walk on counter 0x010 (pc 0x40), with write-first forwarding.
    vecs.push_back(mk(1, 'h010, 1, 1, 'h40, 0, 1, 1, 'h010, 'h01));
    vecs.push_back(mk(1, 'h010, 1, 1, 'h40, 0, 1, 1, 'h010, 'h03));
    vecs.push_back(mk(1, 'h010, 1, 1, 'h40, 0, 1, 1, 'h010, 'h07));
    vecs.push_back(mk(1, 'h010, 0, 1, 'h40, 0, 1, 1, 'h010, 'h0E));
    vecs.push_back(mk(1, 'h010, 0, 1, 'h40, 0, 1, 0, 'h010, 'h1C));
    vecs.push_back(mk(1, 'h010, 0, 1, 'h40, 0, 1, 0, 'h010, 'h38));
    vecs.push_back(mk(0, 0,     0, 1, 'h40, 0, 1, 0, 'h010, 'h38));
    vecs.push_back(mk(1, 'h010, 1, 1, 'h40, 0, 1, 0, 'h010, 'h71));
    vecs.push_back(mk(0, 0,     0, 1, 'h40, 0, 1, 0, 'h010, 'h71));
    // Idle cycle: valid drops, taken/idx hold.
    vecs.push_back(mk(0, 0,     0, 0, 0,    0, 0, 0, 'h010, 'h71));
    // Collision: counter 01 + taken update same cycle -> prediction sees 10.
    vecs.push_back(mk(1, 'h010, 1, 1, 'h40, 0, 1, 1, 'h010, 'hE3));
    // Drive counter 0x010 down to 00.
    vecs.push_back(mk(1, 'h010, 0, 0, 0,    0, 0, 1, 'h010, 'hC6));
    vecs.push_back(mk(1, 'h010, 0, 0, 0,    0, 0, 1, 'h010, 'h8C));
    // History pattern 1,0,1,1,0,0,1,0 via updates on 0x020 -> ghr 0xB2.
    gh_out = '{1, 0, 1, 1, 0, 0, 1, 0};
    gh_exp = '{'h19, 'h32, 'h65, 'hCB, 'h96, 'h2C, 'h59, 'hB2};
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 'h020, gh_out[i], 0, 0, 0, 0, 1, 'h010, gh_exp[i]));
    // Gshare vs bimodal index for pc 0x400, then read back touched counters.
    vecs.push_back(mk(0, 0, 0, 1, 'h400, 1, 1, 1, 'h1B2, 'hB2));
    vecs.push_back(mk(0, 0, 0, 1, 'h400, 0, 1, 1, 'h100, 'hB2));
    vecs.push_back(mk(0, 0, 0, 1, 'h80,  0, 1, 0, 'h020, 'hB2));
    vecs.push_back(mk(0, 0, 0, 1, 'h40,  0, 1, 0, 'h010, 'hB2));

    // 3-bit counter from INIT 100: walk to 111 and past, then to 000 and past.
    svecs = '{'{0, 1}, '{2, 0}, '{1, 1}, '{1, 1}, '{1, 1}, '{1, 1}, '{1, 1},
              '{2, 1}, '{2, 1}, '{2, 1}, '{2, 0}, '{2, 0}, '{2, 0}, '{2, 0}, '{2, 0},
              '{1, 0}, '{1, 0}, '{1, 0}, '{1, 1}};

    repeat (3) tick();

    // Reset state.
    check("rst_ready",   32'(ready), 0);
    check("rst_valid",   32'(pred_valid), 0);
    check("rst_taken",   32'(pred_taken), 0);
    check("rst_idx",     32'(pred_idx), 0);
    check("rst_ghr",     32'(ghr), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_s_ghr",   32'(s_ghr), 0);

    // ---------------- small instance ----------------
    s_rst = 1'b1;
    wait_small_ready(100, n);
    check("s_sweep_len", 32'(n), 16);

    s_pred_req = 1'b1; s_pred_pc = 32'h14; s_upd_idx = 4'h5;
    foreach (svecs[i]) begin
      s_upd_en    = (svecs[i].upd != 0);
      s_upd_taken = (svecs[i].upd == 1);
      tick();
      check($sformatf("s%0d_valid", i), 32'(s_pred_valid), 1);
      check($sformatf("s%0d_taken", i), 32'(s_pred_taken), 32'(svecs[i].exp_taken));
      check($sformatf("s%0d_idx", i),   32'(s_pred_idx), 5);
    end
    s_upd_en = 1'b0; s_pred_req = 1'b0;
    check("s_ghr_run", 32'(s_ghr), 'hF);

    // Asynchronous reset mid-run, observed without a clock edge.
    s_rst = 1'b0;
    #2;
    check("s_arst_ready", 32'(s_ready), 0);
    check("s_arst_valid", 32'(s_pred_valid), 0);
    check("s_arst_taken", 32'(s_pred_taken), 0);
    check("s_arst_ghr",   32'(s_ghr), 0);
    tick();
    s_rst = 1'b1;
    wait_small_ready(100, n);
    check("s_sweep_after_rst", 32'(n), 16);

    // Flush during INIT restarts the sweep at 0.
    s_rst = 1'b0;
    tick();
    s_rst = 1'b1;
    repeat (5) tick();
    check("s_init_ready", 32'(s_ready), 0);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    wait_small_ready(100, n);
    check("s_sweep_after_flush", 32'(n), 16);

    // ---------------- default instance ----------------
    rst = 1'b1; pred_req = 1'b1; pred_pc = 32'h100;
    n = -1; bad = 0;
    for (int i = 1; i <= 5000; i++) begin
      tick();
      if (pred_valid) bad++;
      if (ready) begin
        n = i;
        break;
      end
    end
    check("sweep_len",     32'(n), 4096);
    check("valid_in_init", 32'(bad), 0);
    tick();
    check("first_valid", 32'(pred_valid), 1);
    check("first_taken", 32'(pred_taken), 1);
    check("first_idx",   32'(pred_idx), 'h040);

    foreach (vecs[i]) begin
      upd_en = vecs[i].upd_en; upd_idx = vecs[i].upd_idx; upd_taken = vecs[i].upd_taken;
      pred_req = vecs[i].req;  pred_pc = vecs[i].pc;      mode = vecs[i].mode;
      tick();
      check($sformatf("v%0d_valid", i), 32'(pred_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_taken", i), 32'(pred_taken), 32'(vecs[i].exp_taken));
      check($sformatf("v%0d_idx", i),   32'(pred_idx),   32'(vecs[i].exp_idx));
      check($sformatf("v%0d_ghr", i),   32'(ghr),        32'(vecs[i].exp_ghr));
    end
    upd_en = 1'b0; pred_req = 1'b0; mode = 1'b0;

    // Flush mid-run with ghr 0xB2 and counter[0x010] = 00.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ghr",   32'(ghr), 0);
    check("flush_ready", 32'(ready), 0);
    upd_en = 1'b1; upd_idx = 12'h010; upd_taken = 1'b1;
    tick();
    upd_en = 1'b0;
    check("flush_upd_ghr", 32'(ghr), 0);
    n = -1;
    for (int i = 2; i <= 5000; i++) begin
      tick();
      if (ready) begin
        n = i;
        break;
      end
    end
    check("flush_sweep_len", 32'(n), 4096);
    pred_req = 1'b1; pred_pc = 32'h40;
    tick();
    pred_req = 1'b0;
    check("flush_valid", 32'(pred_valid), 1);
    check("flush_taken", 32'(pred_taken), 1);
    check("flush_ghr_after", 32'(ghr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
